// File: rtl/tagged_scatter_sdf.sv
// tagged_scatter_sdf: dispatches tagged tokens to per-flux output FIFOs, round-robin
// within each flux and realigned to port 0 at every frame boundary.
module tagged_scatter_sdf #(
    parameter  int PORTS     = 2,
    parameter  int FLUX      = 2,
    parameter  int WIDTH     = 8,
    parameter  int NUM_OP    = 4,
    localparam int TAG_WIDTH = $clog2(FLUX),
    localparam int PW        = WIDTH - TAG_WIDTH,
    localparam int PTR_W     = $clog2(PORTS),
    localparam int CNT_W     = $clog2(NUM_OP),
    localparam int N         = PORTS * FLUX,
    localparam int TW        = $clog2(N)
) (
    input  logic             ck,
    input  logic             rst,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_empty,
    output logic             in0_read,
    input  logic [N-1:0]     out_full,
    output logic [N-1:0]     out_wr,
    output logic [PW-1:0]    out_data,
    output logic             out_last,
    output logic             err_drop
);
    logic                 valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic [TW-1:0]        tgt_q, tgt_d;
    logic [PW-1:0]        data_q, data_d;
    logic [PTR_W-1:0]     ptr_q [FLUX];
    logic [PTR_W-1:0]     ptr_d [FLUX];
    logic [CNT_W-1:0]     cnt_q [FLUX];
    logic [CNT_W-1:0]     cnt_d [FLUX];
    logic [TAG_WIDTH-1:0] tag;
    logic                 drain, in_range, wrap;

    assign tag      = in0_data[WIDTH-1:PW];
    assign in_range = int'(tag) < FLUX;
    assign wrap     = cnt_q[tag] == CNT_W'(NUM_OP - 1);
    // Write strobe is combinational on out_full so a full FIFO never sees a write
    assign drain    = valid_q & ~out_full[tgt_q];
    assign out_wr   = drain ? N'(1) << tgt_q : '0;
    assign in0_read = rst & ~in0_empty & (~valid_q | drain);
    assign out_data = data_q;
    assign out_last = last_q;
    assign err_drop = err_q;

    always_comb begin
        valid_d = valid_q & ~drain;
        tgt_d   = tgt_q;
        data_d  = data_q;
        last_d  = last_q;
        err_d   = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (in0_read && in_range) begin
            valid_d    = 1'b1;
            tgt_d      = TW'(int'(tag) * PORTS + int'(ptr_q[tag]));
            data_d     = in0_data[PW-1:0];
            last_d     = wrap;
            cnt_d[tag] = wrap ? '0 : cnt_q[tag] + 1'b1;
            ptr_d[tag] = (wrap || ptr_q[tag] == PTR_W'(PORTS - 1)) ? '0 : ptr_q[tag] + 1'b1;
        end else if (in0_read) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tgt_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int f = 0; f < FLUX; f++) begin
                ptr_q[f] <= '0;
                cnt_q[f] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            tgt_q   <= tgt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
